// File: rtl/sprite_table_writer.sv
// sprite_table_writer
//
// Producer side of the PPU sprite-table update interface. Game logic writes
// sprite records and viewport offsets into shadow registers through a
// valid/ready handshake. At the start of each vertical sync pulse, if anything
// was written since the last commit, the shadow contents are copied to the
// live outputs. `update` is then held high for UPDATE_CYCLES clocks so the
// PPU sees it on both an hsync and a vsync cycle.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   vsync             vertical sync from vga_controller
//   wr_valid/ready    sprite record write handshake (wr_index, wr_x, wr_y,
//                     wr_char, wr_attr)
//   off_valid         viewport offset write (off_x, off_y, static_in); it
//                     shares wr_ready with the sprite write
//   update            commit strobe to the PPU
//   sprites, statics,
//   offset_x/offset_y live tables driven to the PPU
//   frame_done        one-cycle pulse when a commit window ends

module sprite_table_writer #(
  parameter logic VSYNC_ACTIVE  = 1'b0,
  parameter int   UPDATE_CYCLES = 1800,
  parameter int   OFF_MAX_X     = 1024,
  parameter int   OFF_MAX_Y     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_index,
  input  logic [8:0]  wr_x,
  input  logic [8:0]  wr_y,
  input  logic [4:0]  wr_char,
  input  logic [1:0]  wr_attr,
  input  logic        off_valid,
  input  logic [11:0] off_x,
  input  logic [11:0] off_y,
  input  logic        static_in,
  output logic        update,
  output logic [57:0] sprites,
  output logic        statics,
  output logic [11:0] offset_x,
  output logic [11:0] offset_y,
  output logic        frame_done
);

  localparam int              CNT_W    = $clog2(UPDATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(UPDATE_CYCLES - 1);
  localparam logic [11:0]     MAX_X    = 12'(OFF_MAX_X);
  localparam logic [11:0]     MAX_Y    = 12'(OFF_MAX_Y);

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    HOLD,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              vsync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dirty_q, dirty_d;
  logic [27:0]       rec0_q, rec0_d;
  logic [27:0]       rec1_q, rec1_d;
  logic [11:0]       shOffX_q, shOffX_d;
  logic [11:0]       shOffY_q, shOffY_d;
  logic              shStatic_q, shStatic_d;
  logic [57:0]       sprites_q, sprites_d;
  logic              statics_q, statics_d;
  logic [11:0]       offX_q, offX_d;
  logic [11:0]       offY_q, offY_d;

  logic        vsStart;
  logic        spriteAcc;
  logic        offAcc;
  logic [27:0] newRec;

  assign vsStart   = (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);
  assign wr_ready  = (state_q == IDLE) || (state_q == DONE);
  assign update    = (state_q == HOLD);
  assign frame_done = (state_q == DONE);
  assign spriteAcc = wr_valid && wr_ready;
  assign offAcc    = off_valid && wr_ready;
  assign newRec    = {wr_x, wr_y, wr_attr, 3'b000, wr_char};

  assign sprites  = sprites_q;
  assign statics  = statics_q;
  assign offset_x = offX_q;
  assign offset_y = offY_q;

  // Next-state logic. The live registers are loaded on the edge that enters
  // COMMIT, so they are already stable for the whole COMMIT cycle and lead
  // `update` by exactly one clock. Shadow writes are evaluated after the FSM
  // so that a write accepted in the same cycle as vs_start keeps dirty set
  // and lands in the following frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dirty_d    = dirty_q;
    rec0_d     = rec0_q;
    rec1_d     = rec1_q;
    shOffX_d   = shOffX_q;
    shOffY_d   = shOffY_q;
    shStatic_d = shStatic_q;
    sprites_d  = sprites_q;
    statics_d  = statics_q;
    offX_d     = offX_q;
    offY_d     = offY_q;

    unique case (state_q)
      IDLE: begin
        if (vsStart && dirty_q) begin
          state_d   = COMMIT;
          sprites_d = {rec0_q[25:0], 4'b0000, rec1_q};
          statics_d = shStatic_q;
          offX_d    = shOffX_q;
          offY_d    = shOffY_q;
          dirty_d   = 1'b0;
        end
      end
      COMMIT: begin
        cnt_d   = CNT_LOAD;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (spriteAcc) begin
      if (wr_index) begin
        rec1_d = newRec;
      end else begin
        rec0_d = newRec;
      end
    end

    if (offAcc) begin
      shOffX_d   = (off_x > MAX_X) ? MAX_X : off_x;
      shOffY_d   = (off_y > MAX_Y) ? MAX_Y : off_y;
      shStatic_d = static_in;
    end

    if (spriteAcc || offAcc) begin
      dirty_d = 1'b1;
    end
  end

  // The edge register resets to the inactive level so a sync pulse already
  // in progress when reset releases is still detected as a fresh start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      vsync_q    <= ~VSYNC_ACTIVE;
      cnt_q      <= '0;
      dirty_q    <= 1'b0;
      rec0_q     <= '0;
      rec1_q     <= '0;
      shOffX_q   <= '0;
      shOffY_q   <= '0;
      shStatic_q <= 1'b0;
      sprites_q  <= '0;
      statics_q  <= 1'b0;
      offX_q     <= '0;
      offY_q     <= '0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
      rec0_q     <= rec0_d;
      rec1_q     <= rec1_d;
      shOffX_q   <= shOffX_d;
      shOffY_q   <= shOffY_d;
      shStatic_q <= shStatic_d;
      sprites_q  <= sprites_d;
      statics_q  <= statics_d;
      offX_q     <= offX_d;
      offY_q     <= offY_d;
    end
  end

endmodule

// File: tb/tb_sprite_table_writer.sv
// tb_sprite_table_writer
//
// Self-checking bench for sprite_table_writer. A reference model keeps the
// shadow tables as plain arrays; each vsync pulse that should commit pushes
// the expected live frame into a queue, and an independent monitor pops and
// compares it when `update` rises, also checking the hold length, output
// stability, wr_ready and the frame_done pulse.

module tb_sprite_table_writer;

  localparam int UPD = 1800;

  logic        clock;
  logic        reset;
  logic        vsync;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_index;
  logic [8:0]  wr_x;
  logic [8:0]  wr_y;
  logic [4:0]  wr_char;
  logic [1:0]  wr_attr;
  logic        off_valid;
  logic [11:0] off_x;
  logic [11:0] off_y;
  logic        static_in;
  logic        update;
  logic [57:0] sprites;
  logic        statics;
  logic [11:0] offset_x;
  logic [11:0] offset_y;
  logic        frame_done;

  sprite_table_writer #(
    .VSYNC_ACTIVE (1'b0),
    .UPDATE_CYCLES(UPD),
    .OFF_MAX_X    (1024),
    .OFF_MAX_Y    (1024)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .vsync     (vsync),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_index  (wr_index),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_char   (wr_char),
    .wr_attr   (wr_attr),
    .off_valid (off_valid),
    .off_x     (off_x),
    .off_y     (off_y),
    .static_in (static_in),
    .update    (update),
    .sprites   (sprites),
    .statics   (statics),
    .offset_x  (offset_x),
    .offset_y  (offset_y),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [57:0] spr;
    logic        st;
    logic [11:0] ox;
    logic [11:0] oy;
  } frame_t;

  frame_t      expQ[$];
  frame_t      liveExp;
  logic [27:0] mRec[2];
  logic [11:0] mOx;
  logic [11:0] mOy;
  logic        mSt;
  bit          mDirty;

  int checks = 0;
  int failures = 0;
  int framesSeen = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t modelFrame();
    frame_t f;
    f.spr = {mRec[0][25:0], 4'b0000, mRec[1]};
    f.st  = mSt;
    f.ox  = mOx;
    f.oy  = mOy;
    return f;
  endfunction

  task automatic modelReset();
    mRec[0] = '0;
    mRec[1] = '0;
    mOx     = '0;
    mOy     = '0;
    mSt     = 1'b0;
    mDirty  = 1'b0;
    liveExp = '0;
  endtask

  // Monitor: compares each commit window against the scoreboard queue.
  bit     prevUpd = 0;
  int     holdLen = 0;
  bit     stable = 1;
  bit     readyLow = 1;
  frame_t snap;
  frame_t cur;
  frame_t e;

  always @(negedge clock) begin
    if (reset) begin
      prevUpd = 0;
      holdLen = 0;
    end else begin
      cur = {sprites, statics, offset_x, offset_y};
      if (frame_done) begin
        framesSeen++;
        checkOutput("frame_done_follows_hold", 64'(prevUpd), 64'd1);
      end
      if (update && !prevUpd) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_update", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("commit_sprites", 64'(sprites), 64'(e.spr));
          checkOutput("commit_statics", 64'(statics), 64'(e.st));
          checkOutput("commit_offset_x", 64'(offset_x), 64'(e.ox));
          checkOutput("commit_offset_y", 64'(offset_y), 64'(e.oy));
        end
        snap     = cur;
        holdLen  = 1;
        stable   = 1;
        readyLow = 1;
      end else if (update) begin
        holdLen++;
        if (cur !== snap) stable = 0;
      end
      if (update && wr_ready) readyLow = 0;
      if (!update && prevUpd) begin
        checkOutput("hold_length", 64'(holdLen), 64'(UPD));
        checkOutput("live_stable_in_hold", 64'(stable), 64'd1);
        checkOutput("ready_low_in_hold", 64'(readyLow), 64'd1);
        checkOutput("frame_done_at_end", 64'(frame_done), 64'd1);
      end
      prevUpd = update;
    end
  end

  // Drive one write (sprite, offset or both) starting at a negedge; stalls
  // until wr_ready and updates the model when the write is accepted.
  task automatic applyStimulus(input bit doSpr, input bit idx, input logic [8:0] x,
                               input logic [8:0] y, input logic [4:0] ch, input logic [1:0] at,
                               input bit doOff, input logic [11:0] ox, input logic [11:0] oy,
                               input bit st);
    int  budget = 4000;
    bit  rdy = 0;
    wr_valid  = doSpr;
    wr_index  = idx;
    wr_x      = x;
    wr_y      = y;
    wr_char   = ch;
    wr_attr   = at;
    off_valid = doOff;
    off_x     = ox;
    off_y     = oy;
    static_in = st;
    while (budget > 0) begin
      rdy = wr_ready;
      @(negedge clock);
      if (rdy) break;
      budget--;
    end
    wr_valid  = 1'b0;
    off_valid = 1'b0;
    if (!rdy) begin
      checkOutput("write_accept_timeout", 64'd0, 64'd1);
    end else begin
      if (doSpr) mRec[idx] = {x, y, at, 3'b000, ch};
      if (doOff) begin
        mOx = (ox > 12'd1024) ? 12'd1024 : ox;
        mOy = (oy > 12'd1024) ? 12'd1024 : oy;
        mSt = st;
      end
      if (doSpr || doOff) mDirty = 1'b1;
    end
  endtask

  // Vsync pulse starting at a negedge; checks the two-cycle update latency
  // and that an idle pulse leaves everything untouched.
  task automatic vsyncPulse(output bit want);
    frame_t f;
    vsync = 1'b0;
    want  = mDirty;
    if (want) begin
      f = modelFrame();
      expQ.push_back(f);
      liveExp = f;
      mDirty  = 1'b0;
    end
    @(negedge clock);
    checkOutput("update_low_in_commit", 64'(update), 64'd0);
    checkOutput("live_before_update", 64'(sprites), 64'(liveExp.spr));
    @(negedge clock);
    checkOutput("update_latency", 64'(update), 64'(want));
    if (!want) begin
      checkOutput("idle_offset_x", 64'(offset_x), 64'(liveExp.ox));
      checkOutput("idle_offset_y", 64'(offset_y), 64'(liveExp.oy));
    end
    @(negedge clock);
    @(negedge clock);
    vsync = 1'b1;
    @(negedge clock);
  endtask

  task automatic waitFrameDone(input int target);
    int budget = 2500;
    while (framesSeen < target && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (framesSeen < target) checkOutput("frame_done_timeout", 64'(framesSeen), 64'(target));
    @(negedge clock);
  endtask

  task automatic waitUpdate();
    int budget = 20;
    while (!update && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (!update) checkOutput("update_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic runFrame();
    int  f0;
    bit  want;
    f0 = framesSeen;
    vsyncPulse(want);
    if (want) waitFrameDone(f0 + 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int f0;
    bit want;
    modelReset();
    reset = 1'b1;
    vsync = 1'b1;
    wr_valid = 0; wr_index = 0; wr_x = 0; wr_y = 0; wr_char = 0; wr_attr = 0;
    off_valid = 0; off_x = 0; off_y = 0; static_in = 0;
    repeat (3) @(negedge clock);
    checkOutput("reset_update", 64'(update), 64'd0);
    checkOutput("reset_sprites", 64'(sprites), 64'd0);
    checkOutput("reset_statics", 64'(statics), 64'd0);
    checkOutput("reset_offset_x", 64'(offset_x), 64'd0);
    checkOutput("reset_offset_y", 64'(offset_y), 64'd0);
    checkOutput("reset_frame_done", 64'(frame_done), 64'd0);
    checkOutput("reset_wr_ready", 64'(wr_ready), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Slot 0 record with a hand-computed expected value.
    applyStimulus(1, 0, 9'd100, 9'd50, 5'h13, 2'd2, 0, 12'd0, 12'd0, 0);
    runFrame();
    checkOutput("slot0_literal", 64'(sprites[57:32]), 64'd52480531);

    // Second pulse with nothing written: no update, nothing changes.
    f0 = framesSeen;
    runFrame();
    repeat (10) @(negedge clock);
    checkOutput("no_frame_when_clean", 64'(framesSeen), 64'(f0));

    // Offset saturation.
    applyStimulus(0, 0, 9'd0, 9'd0, 5'd0, 2'd0, 1, 12'hFFF, 12'd300, 1);
    runFrame();
    checkOutput("sat_offset_x", 64'(offset_x), 64'd1024);
    checkOutput("sat_offset_y", 64'(offset_y), 64'd300);

    // Last write to a slot wins.
    applyStimulus(1, 1, 9'd7, 9'd9, 5'd3, 2'd1, 0, 12'd0, 12'd0, 0);
    applyStimulus(1, 1, 9'd7, 9'd9, 5'd7, 2'd0, 0, 12'd0, 12'd0, 0);
    runFrame();
    checkOutput("slot1_last_wins", 64'(sprites[7:0]), 64'h07);
    checkOutput("pad_bits_zero", 64'(sprites[31:28]), 64'd0);

    // Write held through HOLD is stalled and lands in the next frame.
    applyStimulus(1, 0, 9'd321, 9'd123, 5'h1A, 2'd3, 0, 12'd0, 12'd0, 0);
    f0 = framesSeen;
    vsyncPulse(want);
    waitUpdate();
    applyStimulus(1, 1, 9'd444, 9'd222, 5'h0C, 2'd2, 1, 12'd777, 12'd2000, 0);
    checkOutput("stalled_write_after_hold", 64'(framesSeen >= f0 + 1), 64'd1);
    waitFrameDone(f0 + 1);
    runFrame();

    // Reset 500 cycles into HOLD.
    applyStimulus(1, 0, 9'd5, 9'd6, 5'd1, 2'd1, 1, 12'd40, 12'd50, 1);
    vsyncPulse(want);
    waitUpdate();
    repeat (499) @(negedge clock);
    f0 = framesSeen;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midhold_update", 64'(update), 64'd0);
    checkOutput("midhold_sprites", 64'(sprites), 64'd0);
    checkOutput("midhold_offset_x", 64'(offset_x), 64'd0);
    checkOutput("midhold_wr_ready", 64'(wr_ready), 64'd1);
    checkOutput("midhold_frame_done", 64'(frame_done), 64'd0);
    reset = 1'b0;
    modelReset();
    repeat (20) @(negedge clock);
    checkOutput("midhold_no_frame_done", 64'(framesSeen), 64'(f0));

    // Randomized frames; some have no writes and must not commit.
    for (int fr = 0; fr < 8; fr++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        bit ds, dof;
        ds  = $urandom_range(0, 1);
        dof = $urandom_range(0, 1);
        if (!ds && !dof) ds = 1;
        applyStimulus(ds, 1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom),
                      5'($urandom), 2'($urandom), dof, 12'($urandom), 12'($urandom),
                      1'($urandom_range(0, 1)));
      end
      runFrame();
    end

    repeat (5) @(negedge clock);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
